instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage feeding CONTROL: holds the PC, reads instruction memory over a
//  req/ack handshake, and presents the 32-bit instruction word (drives CONTROL
//  Opcode) for one execute slot. Consumes CONTROL's Branch/Jump/Jal/Jr plus the
//  ALU Zero flag to select the next PC. Supplies pc_plus4 for the jal link write.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  MAX_WAIT   16             imem wait cycles tolerated before fetch_err
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  imem_req     out  1   fetch request, held until imem_ack
//  imem_addr    out  32  word address = pc
//  imem_ack     in   1   read data valid this cycle
//  imem_rdata   in   32  instruction word
//  stall        in   1   hold current instruction (no PC update)
//  Branch       in   1   from CONTROL
//  Zero         in   1   from ALU
//  Jump         in   1   from CONTROL
//  Jal          in   1   from CONTROL
//  Jr           in   1   from CONTROL
//  branch_imm   in   32  sign-extended 16-bit immediate
//  jr_target    in   32  rs register value
//  instr        out  32  instruction to CONTROL (Opcode)
//  instr_valid  out  1   instr valid, execute slot active
//  pc           out  32  address of instr
//  pc_plus4     out  32  pc + 4 (link value)
//  fetch_err    out  1   sticky: misaligned target or imem timeout
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, state=S_REQ, instr=0, instr_valid=0,
//   fetch_err=0, wait_cnt=0; imem_req gated 0 while rst=1.
//  States: S_REQ, S_EXEC, S_HALT.
//  S_REQ: imem_req=1, imem_addr=pc. imem_ack=1 -> instr<=imem_rdata,
//   instr_valid<=1, wait_cnt<=0, go S_EXEC. Ack may arrive in the first req
//   cycle (1-cycle fetch min). No ack -> wait_cnt++; wait_cnt reaching
//   MAX_WAIT -> fetch_err<=1, go S_HALT.
//  S_EXEC: imem_req=0. stall=1 -> hold all state, instr stable. stall=0 ->
//   pc<=next_pc, instr_valid<=0, go S_REQ. One fetch per 2+ cycles (no overlap).
//  next_pc priority (sampled only in S_EXEC with stall=0):
//   Jr -> jr_target; else Jump|Jal -> {pc_plus4[31:28], instr[25:0], 2'b00};
//   else Branch&Zero -> pc_plus4 + (branch_imm<<2); else pc_plus4.
//   All adds modulo 2^32 (wrap silently, 32'hFFFF_FFFC+4 = 0).
//  next_pc[1:0]!=0 -> pc not updated, fetch_err<=1, go S_HALT.
//  S_HALT: imem_req=0, instr_valid=0, pc frozen; exit only via rst.
//  pc_plus4 = pc+4, combinational. Redirect inputs ignored outside S_EXEC.
//  imem_ack while not in S_REQ ignored. Reset mid-fetch drops request at once.
// TESTING
//  Reset then ack after 2 waits with 32'h2008_0005 -> req held 3 cycles,
//   instr=32'h2008_0005, instr_valid=1, pc=0.
//  Sequential: 3 fetches, no control -> imem_addr 0,4,8.
//  pc=0x10, Branch=1 Zero=1 imm=-2 -> next imem_addr=0x0C; Zero=0 -> 0x14.
//  pc=0x1000_0040, instr=32'h0C00_0010, Jal=1 -> addr=0x1000_0040, pc_plus4=0x1000_0044.
//  Jr=1 & Jump=1, jr_target=0x80 -> addr 0x80; jr_target=0x82 -> fetch_err=1, S_HALT.
//  stall=1 for 4 cycles in S_EXEC -> instr/pc stable, no req; rst during S_REQ
//   wait -> req=0 immediately, pc=RESET_PC; ack never -> fetch_err after MAX_WAIT.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC holder and imem req/ack fetcher that presents one instruction per execute slot
//  clk, rst(async, active-high)
//  imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//  stall, Branch, Zero, Jump, Jal, Jr, branch_imm, jr_target : next-PC controls
//  instr, instr_valid, pc, pc_plus4 : execute-slot outputs; fetch_err : sticky error
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        Jal,
  input  logic        Jr,
  input  logic [31:0] branch_imm,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {S_REQ, S_EXEC, S_HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, instr_n, next_pc;
  logic valid_n, err_n;
  logic [CW-1:0] wait_cnt, wait_n;
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // request drops combinationally the moment reset asserts
  assign imem_req  = (state == S_REQ) && !rst;
  assign next_pc = Jr            ? jr_target :
                   (Jump | Jal)  ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                   (Branch & Zero) ? pc_plus4 + {branch_imm[29:0], 2'b00} :
                   pc_plus4;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      fetch_err   <= err_n;
      wait_cnt    <= wait_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    valid_n = instr_valid;
    err_n   = fetch_err;
    wait_n  = wait_cnt;
    case (state)
      S_REQ: begin
        if (imem_ack) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          wait_n  = '0;
          state_n = S_EXEC;
        end else begin
          wait_n = wait_cnt + CW'(1);
          if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            err_n   = 1'b1;
            state_n = S_HALT;
          end
        end
      end
      S_EXEC: begin
        if (!stall) begin
          valid_n = 1'b0;
          // a misaligned target freezes the PC at the offending instruction
          if (next_pc[1:0] != 2'b00) begin
            err_n   = 1'b1;
            state_n = S_HALT;
          end else begin
            pc_n    = next_pc;
            state_n = S_REQ;
          end
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = S_HALT;
      end
    endcase
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch
module tb_instruction_fetch;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic stall = 1'b0, Branch = 1'b0, Zero = 1'b0, Jump = 1'b0, Jal = 1'b0, Jr = 1'b0;
  logic [31:0] branch_imm = '0, jr_target = '0;
  logic [31:0] instr, pc, pc_plus4;
  logic instr_valid, fetch_err;
  int n_vec = 0, n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mpc = '0, minstr = '0;

  instruction_fetch #(.RESET_PC(32'h0), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .Branch(Branch), .Zero(Zero), .Jump(Jump), .Jal(Jal), .Jr(Jr),
    .branch_imm(branch_imm), .jr_target(jr_target), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] data, input int waits);
    int n = 0;
    logic [31:0] ea;
    check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
    ea = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", imem_req, 1'b1);
    check("fetch_addr", imem_addr, ea);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("req_held", imem_req, 1'b1);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    check("instr_valid", instr_valid, 1'b1);
    check("instr", instr, data);
    check("pc", pc, ea);
    check("pc_plus4", pc_plus4, ea + 32'd4);
    check("req_dropped", imem_req, 1'b0);
    mpc = ea;
    minstr = data;
  endtask

  task automatic step(input logic [4:0] ctl, input logic [31:0] imm, input logic [31:0] jrt,
                      input logic [31:0] exp_addr);
    {Branch, Zero, Jump, Jal, Jr} = ctl;
    branch_imm = imm;
    jr_target = jrt;
    @(negedge clk);
    {Branch, Zero, Jump, Jal, Jr} = '0;
    check("slot_closed", instr_valid, 1'b0);
    if (exp_addr[1:0] == 2'b00) begin
      exp_q.push_back(exp_addr);
      check("next_req", imem_req, 1'b1);
    end else begin
      check("misalign_err", fetch_err, 1'b1);
      check("misalign_pc_frozen", pc, mpc);
      check("misalign_no_req", imem_req, 1'b0);
    end
  endtask

  initial begin
    int k;
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_err", fetch_err, 1'b0);
    check("rst_instr", instr, 32'h0);
    rst = 1'b0;
    exp_q.push_back(32'h0);
    do_fetch(32'h2008_0005, 2);
    step(5'b00000, 0, 0, 32'h4);  do_fetch(32'h0000_0020, 0);
    step(5'b00000, 0, 0, 32'h8);  do_fetch(32'h0000_0021, 1);
    step(5'b00000, 0, 0, 32'hC);  do_fetch(32'h0000_0022, 0);
    step(5'b00000, 0, 0, 32'h10); do_fetch(32'h1000_FFFE, 0);
    step(5'b11000, 32'hFFFF_FFFE, 0, 32'h0C); do_fetch(32'h0000_0023, 0);
    step(5'b00000, 0, 0, 32'h10); do_fetch(32'h1000_FFFE, 0);
    step(5'b10000, 32'hFFFF_FFFE, 0, 32'h14); do_fetch(32'h0000_0024, 0);
    step(5'b00001, 0, 32'h1000_0040, 32'h1000_0040); do_fetch(32'h0C00_0010, 0);
    step(5'b00010, 0, 0, 32'h1000_0040); do_fetch(32'h0C00_0010, 3);
    check("jal_link", pc_plus4, 32'h1000_0044);
    stall = 1'b1;
    Jr = 1'b1;
    jr_target = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_instr", instr, 32'h0C00_0010);
      check("stall_pc", pc, 32'h1000_0040);
      check("stall_req", imem_req, 1'b0);
      check("stall_valid", instr_valid, 1'b1);
    end
    Jr = 1'b0;
    stall = 1'b0;
    step(5'b00101, 0, 32'h80, 32'h80); do_fetch(32'h0800_0004, 0);
    step(5'b00100, 0, 0, 32'h10); do_fetch(32'h0000_0025, 0);
    step(5'b00001, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC); do_fetch(32'h0000_0026, 0);
    step(5'b00000, 0, 0, 32'h0); do_fetch(32'h0000_0027, 0);
    step(5'b00101, 0, 32'h82, 32'h82);
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    check("halt_req", imem_req, 1'b0);
    check("halt_valid", instr_valid, 1'b0);
    check("halt_instr", instr, 32'h0000_0027);
    check("halt_pc", pc, 32'h0);
    check("halt_err", fetch_err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_err", fetch_err, 1'b0);
    rst = 1'b0;
    exp_q.push_back(32'h0);
    do_fetch(32'h2402_0001, 0);
    step(5'b00001, 0, 32'h40, 32'h40);
    repeat (3) begin
      @(negedge clk);
      check("wait_addr", imem_addr, 32'h40);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", imem_req, 1'b0);
    check("rst_mid_pc", pc, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (!fetch_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, 32'd16);
    check("timeout_req", imem_req, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
